dmem_arbiter: RTL and testbench



---
 rtl/dmem_arbiter.sv | 151 +++++++++++++++
 tb/tb_dmem_arbiter.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing the main_mem data port between the LSU (r0) and
// the loader (r1); converts sized byte requests to word/lane form and sequences fence.i.
module dmem_arbiter #(
   parameter int ADDR_W = 14
) (
   input  logic              clk,
   input  logic              i_rst,
   input  logic              i_r0_req,
   input  logic              i_r0_we,
   input  logic [31:0]       i_r0_addr,
   input  logic [1:0]        i_r0_size,
   input  logic [31:0]       i_r0_wdata,
   output logic              o_r0_gnt,
   output logic              o_r0_rvalid,
   output logic [31:0]       o_r0_rdata,
   output logic              o_r0_err,
   input  logic              i_r1_req,
   input  logic              i_r1_we,
   input  logic [31:0]       i_r1_addr,
   input  logic [1:0]        i_r1_size,
   input  logic [31:0]       i_r1_wdata,
   output logic              o_r1_gnt,
   output logic              o_r1_rvalid,
   output logic [31:0]       o_r1_rdata,
   output logic              o_r1_err,
   input  logic              i_fence_req,
   output logic              o_fence_done,
   output logic              o_dm_ren,
   output logic              o_dm_wen,
   output logic [3:0]        o_dm_ben,
   output logic [ADDR_W-1:0] o_dm_addr,
   output logic [31:0]       o_dm_wdata,
   input  logic [31:0]       i_dm_rdata,
   output logic              o_fence_i,
   input  logic              i_mem_ready
);

   typedef enum logic [1:0] {S_IDLE, S_FENCE, S_FWAIT} state_t;

   state_t      state, state_nx;
   logic        fwait_seen;
   logic        last;
   logic        gnt_any, gnt_id;
   logic        req_we;
   logic [1:0]  req_size, off;
   logic [31:0] req_wdata;
   logic        misal;
   logic [3:0]  ben;
   logic [31:0] wdata_rep;
   logic [1:0]  rvalid_q, err_q;
   logic [1:0]  off_q;
   logic [31:0] rshift;
   logic        unused_addr_bits;

   assign unused_addr_bits = ^{i_r0_addr[31:ADDR_W+2], i_r1_addr[31:ADDR_W+2]};

   always_comb begin
      state_nx     = state;
      o_fence_i    = 1'b0;
      o_fence_done = 1'b0;
      gnt_any      = 1'b0;
      gnt_id       = 1'b0;
      case (state)
         S_IDLE: begin
            if (i_fence_req) begin
               state_nx = S_FENCE;
            end else if (!i_rst && i_mem_ready && (i_r0_req || i_r1_req)) begin
               gnt_any = 1'b1;
               gnt_id  = (i_r0_req && i_r1_req) ? ~last : i_r1_req;
            end
         end
         S_FENCE: begin
            o_fence_i = 1'b1;
            state_nx  = S_FWAIT;
         end
         S_FWAIT: begin
            // fwait_seen marks the second and later FWAIT cycles
            if (!i_rst && fwait_seen && i_mem_ready) begin
               o_fence_done = 1'b1;
               state_nx     = S_IDLE;
            end
         end
         default: state_nx = S_IDLE;
      endcase
   end

   assign req_we    = gnt_id ? i_r1_we    : i_r0_we;
   assign req_size  = gnt_id ? i_r1_size  : i_r0_size;
   assign req_wdata = gnt_id ? i_r1_wdata : i_r0_wdata;
   assign off       = gnt_id ? i_r1_addr[1:0] : i_r0_addr[1:0];
   assign o_dm_addr = gnt_id ? i_r1_addr[ADDR_W+1:2] : i_r0_addr[ADDR_W+1:2];

   assign misal = (req_size == 2'b11) || (req_size == 2'b01 && off[0]) ||
                  (req_size == 2'b10 && off != 2'b00);

   always_comb begin
      ben       = 4'b1111;
      wdata_rep = req_wdata;
      case (req_size)
         2'b00: begin
            ben       = 4'b0001 << off;
            wdata_rep = {4{req_wdata[7:0]}};
         end
         2'b01: begin
            ben       = 4'b0011 << off;
            wdata_rep = {2{req_wdata[15:0]}};
         end
         default: ;
      endcase
   end

   assign o_dm_ren   = gnt_any && !misal && !req_we;
   assign o_dm_wen   = gnt_any && !misal && req_we;
   assign o_dm_ben   = o_dm_wen ? ben : (o_dm_ren ? 4'b1111 : 4'b0000);
   assign o_dm_wdata = wdata_rep;
   assign o_r0_gnt   = gnt_any && !gnt_id;
   assign o_r1_gnt   = gnt_any && gnt_id;

   always_ff @(posedge clk) begin
      if (i_rst) begin
         state      <= S_IDLE;
         fwait_seen <= 1'b0;
         last       <= 1'b1;
         rvalid_q   <= '0;
         err_q      <= '0;
         off_q      <= '0;
      end else begin
         state      <= state_nx;
         fwait_seen <= (state == S_FWAIT);
         rvalid_q   <= '0;
         err_q      <= '0;
         off_q      <= off;
         if (gnt_any) begin
            last <= gnt_id;
            if (misal)
               err_q[gnt_id] <= 1'b1;
            else if (!req_we)
               rvalid_q[gnt_id] <= 1'b1;
         end
      end
   end

   assign rshift      = i_dm_rdata >> {off_q, 3'b000};
   assign o_r0_rvalid = rvalid_q[0];
   assign o_r1_rvalid = rvalid_q[1];
   assign o_r0_err    = err_q[0];
   assign o_r1_err    = err_q[1];
   assign o_r0_rdata  = rvalid_q[0] ? rshift : '0;
   assign o_r1_rdata  = rvalid_q[1] ? rshift : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: directed stimulus pushes expected grants,
// responses and fence events; a negedge monitor pops and compares them.
module tb_dmem_arbiter;

   logic        clk = 1'b0;
   logic        i_rst;
   logic        i_r0_req, i_r0_we, i_r1_req, i_r1_we;
   logic [31:0] i_r0_addr, i_r0_wdata, i_r1_addr, i_r1_wdata;
   logic [1:0]  i_r0_size, i_r1_size;
   logic        o_r0_gnt, o_r0_rvalid, o_r0_err, o_r1_gnt, o_r1_rvalid, o_r1_err;
   logic [31:0] o_r0_rdata, o_r1_rdata;
   logic        i_fence_req, o_fence_done, o_fence_i, i_mem_ready;
   logic        o_dm_ren, o_dm_wen;
   logic [3:0]  o_dm_ben;
   logic [13:0] o_dm_addr;
   logic [31:0] o_dm_wdata, i_dm_rdata;

   dmem_arbiter #(.ADDR_W(14)) dut (
      .clk(clk), .i_rst(i_rst),
      .i_r0_req(i_r0_req), .i_r0_we(i_r0_we), .i_r0_addr(i_r0_addr),
      .i_r0_size(i_r0_size), .i_r0_wdata(i_r0_wdata),
      .o_r0_gnt(o_r0_gnt), .o_r0_rvalid(o_r0_rvalid), .o_r0_rdata(o_r0_rdata), .o_r0_err(o_r0_err),
      .i_r1_req(i_r1_req), .i_r1_we(i_r1_we), .i_r1_addr(i_r1_addr),
      .i_r1_size(i_r1_size), .i_r1_wdata(i_r1_wdata),
      .o_r1_gnt(o_r1_gnt), .o_r1_rvalid(o_r1_rvalid), .o_r1_rdata(o_r1_rdata), .o_r1_err(o_r1_err),
      .i_fence_req(i_fence_req), .o_fence_done(o_fence_done),
      .o_dm_ren(o_dm_ren), .o_dm_wen(o_dm_wen), .o_dm_ben(o_dm_ben),
      .o_dm_addr(o_dm_addr), .o_dm_wdata(o_dm_wdata), .i_dm_rdata(i_dm_rdata),
      .o_fence_i(o_fence_i), .i_mem_ready(i_mem_ready)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          cyc;
      logic        id;
      logic        ren;
      logic        wen;
      logic [3:0]  ben;
      logic [13:0] addr;
      logic [31:0] wdata;
   } gnt_t;
   typedef struct {
      int          cyc;
      logic        id;
      logic        err;
      logic [31:0] rdata;
   } rsp_t;
   typedef struct {
      int   cyc;
      logic done;
   } fen_t;

   gnt_t gq[$];
   rsp_t rq[$];
   fen_t fq[$];
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic void eg(int c, logic id, logic ren, logic wen, logic [3:0] ben,
                              logic [13:0] a, logic [31:0] wd);
      gnt_t g;
      g.cyc = c; g.id = id; g.ren = ren; g.wen = wen; g.ben = ben; g.addr = a; g.wdata = wd;
      gq.push_back(g);
   endfunction

   function automatic void er(int c, logic id, logic err, logic [31:0] rd);
      rsp_t r;
      r.cyc = c; r.id = id; r.err = err; r.rdata = rd;
      rq.push_back(r);
   endfunction

   function automatic void ef(int c, logic done);
      fen_t f;
      f.cyc = c; f.done = done;
      fq.push_back(f);
   endfunction

   // monitor
   gnt_t        mg;
   rsp_t        mr;
   fen_t        mf;
   logic        ok, obs_id, obs_err, obs_rv;
   logic [31:0] obs_rd;

   always @(negedge clk) begin
      if (o_r0_gnt && o_r1_gnt) begin
         checks++; errors++;
         $display("FAIL gnt_both cyc=%0d got both grants, required at most one", cyc);
      end else if (o_r0_gnt || o_r1_gnt) begin
         checks++;
         if (gq.size() == 0) begin
            errors++;
            $display("FAIL gnt_unexpected cyc=%0d got grant id=%0d, required none", cyc, o_r1_gnt);
         end else begin
            mg = gq.pop_front();
            ok = (mg.cyc == cyc) && (mg.id == o_r1_gnt) && (mg.ren == o_dm_ren) && (mg.wen == o_dm_wen);
            if (mg.ren || mg.wen) ok = ok && (mg.addr == o_dm_addr) && (mg.ben == o_dm_ben);
            if (mg.wen) ok = ok && (mg.wdata == o_dm_wdata);
            if (!ok) begin
               errors++;
               $display("FAIL gnt cyc=%0d got id=%0d ren=%0b wen=%0b ben=%b addr=%h wdata=%h, required cyc=%0d id=%0d ren=%0b wen=%0b ben=%b addr=%h wdata=%h",
                        cyc, o_r1_gnt, o_dm_ren, o_dm_wen, o_dm_ben, o_dm_addr, o_dm_wdata,
                        mg.cyc, mg.id, mg.ren, mg.wen, mg.ben, mg.addr, mg.wdata);
            end
         end
      end else begin
         checks++;
         if (o_dm_ren || o_dm_wen || o_dm_ben != 4'b0000) begin
            errors++;
            $display("FAIL strobe_idle cyc=%0d got ren=%0b wen=%0b ben=%b, required all 0",
                     cyc, o_dm_ren, o_dm_wen, o_dm_ben);
         end
      end

      if ((o_r0_rvalid || o_r0_err) && (o_r1_rvalid || o_r1_err)) begin
         checks++; errors++;
         $display("FAIL rsp_both cyc=%0d got responses on both requesters, required at most one", cyc);
      end else if (o_r0_rvalid || o_r0_err || o_r1_rvalid || o_r1_err) begin
         checks++;
         obs_id  = o_r1_rvalid || o_r1_err;
         obs_err = obs_id ? o_r1_err : o_r0_err;
         obs_rv  = obs_id ? o_r1_rvalid : o_r0_rvalid;
         obs_rd  = obs_id ? o_r1_rdata : o_r0_rdata;
         if (rq.size() == 0) begin
            errors++;
            $display("FAIL rsp_unexpected cyc=%0d got id=%0d rvalid=%0b err=%0b, required none",
                     cyc, obs_id, obs_rv, obs_err);
         end else begin
            mr = rq.pop_front();
            ok = (mr.cyc == cyc) && (mr.id == obs_id) && (mr.err == obs_err) && (obs_rv == !mr.err);
            if (!mr.err) ok = ok && (mr.rdata == obs_rd);
            if (!ok) begin
               errors++;
               $display("FAIL rsp cyc=%0d got id=%0d rvalid=%0b err=%0b rdata=%h, required cyc=%0d id=%0d err=%0b rdata=%h",
                        cyc, obs_id, obs_rv, obs_err, obs_rd, mr.cyc, mr.id, mr.err, mr.rdata);
            end
         end
      end

      if (o_fence_i || o_fence_done) begin
         checks++;
         if (fq.size() == 0) begin
            errors++;
            $display("FAIL fence_unexpected cyc=%0d got fence_i=%0b done=%0b, required none",
                     cyc, o_fence_i, o_fence_done);
         end else begin
            mf = fq.pop_front();
            if (mf.cyc != cyc || mf.done != o_fence_done || o_fence_i == mf.done) begin
               errors++;
               $display("FAIL fence cyc=%0d got fence_i=%0b done=%0b, required cyc=%0d done=%0b",
                        cyc, o_fence_i, o_fence_done, mf.cyc, mf.done);
            end
         end
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic set_r(input int n, input logic req, input logic we, input logic [31:0] a,
                        input logic [1:0] sz, input logic [31:0] wd);
      if (n == 0) begin
         i_r0_req = req; i_r0_we = we; i_r0_addr = a; i_r0_size = sz; i_r0_wdata = wd;
      end else begin
         i_r1_req = req; i_r1_we = we; i_r1_addr = a; i_r1_size = sz; i_r1_wdata = wd;
      end
   endtask

   task automatic check_zero(input string name);
      logic [13:0] flags;
      flags = {o_r0_gnt, o_r1_gnt, o_r0_rvalid, o_r1_rvalid, o_r0_err, o_r1_err,
               o_dm_ren, o_dm_wen, o_dm_ben, o_fence_i, o_fence_done};
      checks++;
      if (flags != 14'd0) begin
         errors++;
         $display("FAIL %s_flags got %b, required all 0", name, flags);
      end
      checks++;
      if (o_r0_rdata != 32'd0 || o_r1_rdata != 32'd0) begin
         errors++;
         $display("FAIL %s_rdata got r0=%h r1=%h, required 0", name, o_r0_rdata, o_r1_rdata);
      end
   endtask

   int c, t;

   initial begin
      i_rst = 1'b1; i_fence_req = 1'b0; i_mem_ready = 1'b1; i_dm_rdata = 32'hDEAD_BEEF;
      set_r(0, 0, 0, 0, 0, 0);
      set_r(1, 0, 0, 0, 0, 0);
      tick; tick;
      check_zero("reset");
      i_rst = 1'b0;

      // both loads held from reset: r0, r1, r0, r1
      tick; c = cyc;
      set_r(0, 1, 0, 32'h10, 2'b10, 0);
      set_r(1, 1, 0, 32'h12, 2'b00, 0);
      for (int i = 0; i < 4; i++) begin
         eg(c + i, i[0], 1, 0, 4'b1111, 14'd4, 0);
         er(c + i + 1, i[0], 0, i[0] ? 32'h0000_DEAD : 32'hDEAD_BEEF);
      end
      repeat (4) tick;
      set_r(0, 0, 0, 0, 0, 0);
      set_r(1, 0, 0, 0, 0, 0);

      // stores and sized loads, back to back
      tick;
      set_r(1, 1, 1, 32'h13, 2'b00, 32'h1234_56A5);
      eg(cyc, 1, 0, 1, 4'b1000, 14'd4, 32'hA5A5_A5A5);
      tick;
      set_r(1, 0, 0, 0, 0, 0);
      set_r(0, 1, 1, 32'h22, 2'b01, 32'hBEEF_1234);
      eg(cyc, 0, 0, 1, 4'b1100, 14'd8, 32'h1234_1234);
      tick;
      set_r(0, 1, 0, 32'h11, 2'b00, 0);
      eg(cyc, 0, 1, 0, 4'b1111, 14'd4, 0);
      er(cyc + 1, 0, 0, 32'h00DE_ADBE);
      tick;
      set_r(0, 0, 0, 0, 0, 0);
      set_r(1, 1, 0, 32'h16, 2'b01, 0);
      eg(cyc, 1, 1, 0, 4'b1111, 14'd5, 0);
      er(cyc + 1, 1, 0, 32'h0000_DEAD);
      tick;
      set_r(1, 1, 1, 32'h2C, 2'b10, 32'h0BAD_F00D);
      eg(cyc, 1, 0, 1, 4'b1111, 14'd11, 32'h0BAD_F00D);

      // misaligned / illegal: consumed, no strobe, err next cycle
      tick;
      set_r(1, 0, 0, 0, 0, 0);
      set_r(0, 1, 0, 32'h3, 2'b01, 0);
      eg(cyc, 0, 0, 0, 0, 0, 0); er(cyc + 1, 0, 1, 0);
      tick;
      set_r(0, 0, 0, 0, 0, 0);
      set_r(1, 1, 1, 32'h8, 2'b11, 32'h1);
      eg(cyc, 1, 0, 0, 0, 0, 0); er(cyc + 1, 1, 1, 0);
      tick;
      set_r(1, 0, 0, 0, 0, 0);
      set_r(0, 1, 0, 32'h6, 2'b10, 0);
      eg(cyc, 0, 0, 0, 0, 0, 0); er(cyc + 1, 0, 1, 0);
      tick;
      set_r(0, 0, 0, 0, 0, 0);
      set_r(1, 1, 1, 32'h5, 2'b01, 32'h7);
      eg(cyc, 1, 0, 0, 0, 0, 0); er(cyc + 1, 1, 1, 0);
      tick;
      set_r(1, 0, 0, 0, 0, 0);

      // mem not ready in IDLE: request waits, granted exactly once
      tick; c = cyc;
      set_r(0, 1, 0, 32'h40, 2'b10, 0);
      i_mem_ready = 1'b0;
      tick; tick;
      i_mem_ready = 1'b1;
      eg(c + 2, 0, 1, 0, 4'b1111, 14'd16, 0);
      er(c + 3, 0, 0, 32'hDEAD_BEEF);
      tick;
      set_r(0, 0, 0, 0, 0, 0);

      // load in flight, then fence while both request
      tick; c = cyc;
      set_r(0, 1, 0, 32'h10, 2'b10, 0);
      eg(c, 0, 1, 0, 4'b1111, 14'd4, 0);
      er(c + 1, 0, 0, 32'hDEAD_BEEF);
      tick; t = cyc;
      i_fence_req = 1'b1;
      set_r(1, 1, 0, 32'h20, 2'b10, 0);
      ef(t + 1, 0);
      tick; tick;
      i_mem_ready = 1'b0;
      tick; tick; tick;
      i_mem_ready = 1'b1;
      ef(t + 5, 1);
      tick;
      i_fence_req = 1'b0;
      eg(t + 6, 1, 1, 0, 4'b1111, 14'd8, 0); er(t + 7, 1, 0, 32'hDEAD_BEEF);
      eg(t + 7, 0, 1, 0, 4'b1111, 14'd4, 0); er(t + 8, 0, 0, 32'hDEAD_BEEF);
      tick; tick;
      set_r(0, 0, 0, 0, 0, 0);
      set_r(1, 0, 0, 0, 0, 0);

      // reset during FWAIT
      tick; t = cyc;
      i_fence_req = 1'b1;
      ef(t + 1, 0);
      tick; tick;
      i_rst = 1'b1;
      i_fence_req = 1'b0;
      tick;
      i_rst = 1'b0;
      check_zero("rst_fwait");
      repeat (3) tick;
      set_r(0, 1, 0, 32'h13, 2'b00, 0);
      eg(cyc, 0, 1, 0, 4'b1111, 14'd4, 0);
      er(cyc + 1, 0, 0, 32'h0000_00DE);
      tick;
      set_r(0, 0, 0, 0, 0, 0);

      repeat (4) tick;
      checks++;
      if (gq.size() != 0) begin
         errors++; $display("FAIL gnt_pending got %0d left, required 0", gq.size());
      end
      checks++;
      if (rq.size() != 0) begin
         errors++; $display("FAIL rsp_pending got %0d left, required 0", rq.size());
      end
      checks++;
      if (fq.size() != 0) begin
         errors++; $display("FAIL fence_pending got %0d left, required 0", fq.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
